// File: rtl/ysyx_24110015_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and reset PC.
package ysyx_24110015_ifu_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    typedef enum logic [2:0] {
        IFU_IDLE = 3'd0,
        IFU_REQ  = 3'd1,
        IFU_WAIT = 3'd2,
        IFU_HOLD = 3'd3,
        IFU_HALT = 3'd4
    } ifu_state_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_24110015_ifu.sv
// Instruction fetch unit: owns the PC, keeps at most one imem read in flight and holds
// the fetched word for the IDU until it is taken, redirected away, or fetch stops.
module ysyx_24110015_ifu
    import ysyx_24110015_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic        fetch_fault
);

    ifu_state_e  r_state, w_state_n;
    logic [31:0] r_pc, w_pc_n;
    logic [31:0] r_inst, w_inst_n;
    logic [31:0] r_inst_pc, w_inst_pc_n;
    logic        r_drop, w_drop_n;
    logic        r_stop, w_stop_n;
    logic        r_fault, w_fault_n;
    logic        w_bad_redir;

    // r_drop: the in-flight response belongs to a squashed fetch.
    // r_stop: halt/fault arrived while a request was outstanding; go to HALT once drained.
    assign w_bad_redir = redirect_valid & is_misaligned(redirect_pc);

    always_comb begin
        w_state_n   = r_state;
        w_pc_n      = r_pc;
        w_inst_n    = r_inst;
        w_inst_pc_n = r_inst_pc;
        w_drop_n    = r_drop;
        w_stop_n    = r_stop;
        w_fault_n   = r_fault;
        case (r_state)
            IFU_IDLE: w_state_n = halt ? IFU_HALT : IFU_REQ;
            IFU_REQ: begin
                if (w_bad_redir || halt) begin
                    w_fault_n = r_fault | w_bad_redir;
                    if (imem_req_ready) begin
                        w_drop_n  = 1'b1;
                        w_stop_n  = 1'b1;
                        w_state_n = IFU_WAIT;
                    end else begin
                        w_state_n = IFU_HALT;
                    end
                end else if (redirect_valid) begin
                    w_pc_n = redirect_pc;
                    if (imem_req_ready) begin
                        w_drop_n  = 1'b1;
                        w_state_n = IFU_WAIT;
                    end
                end else if (imem_req_ready) begin
                    w_state_n = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (w_bad_redir || halt) begin
                    w_fault_n = r_fault | w_bad_redir;
                    w_stop_n  = 1'b1;
                end else if (redirect_valid) begin
                    w_pc_n = redirect_pc;
                end
                if (imem_rsp_valid) begin
                    w_drop_n = 1'b0;
                    if (!r_drop && imem_rsp_err) begin
                        w_fault_n = 1'b1;
                        w_state_n = IFU_HALT;
                    end else if (w_stop_n) begin
                        w_state_n = IFU_HALT;
                    end else if (r_drop || redirect_valid) begin
                        w_state_n = IFU_REQ;
                    end else begin
                        w_inst_n    = imem_rsp_data;
                        w_inst_pc_n = r_pc;
                        w_state_n   = IFU_HOLD;
                    end
                end else if (redirect_valid || halt) begin
                    w_drop_n = 1'b1;
                end
            end
            IFU_HOLD: begin
                // A redirect squashes the held word even if the IDU is ready this cycle.
                if (w_bad_redir) begin
                    w_fault_n = 1'b1;
                    w_state_n = IFU_HALT;
                end else if (halt) begin
                    w_state_n = IFU_HALT;
                end else if (redirect_valid) begin
                    w_pc_n    = redirect_pc;
                    w_state_n = IFU_REQ;
                end else if (inst_ready) begin
                    w_pc_n    = r_pc + 32'd4;
                    w_state_n = IFU_REQ;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IFU_IDLE;
            r_pc      <= RESET_PC;
            r_inst    <= 32'h0;
            r_inst_pc <= RESET_PC;
            r_drop    <= 1'b0;
            r_stop    <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_pc      <= w_pc_n;
            r_inst    <= w_inst_n;
            r_inst_pc <= w_inst_pc_n;
            r_drop    <= w_drop_n;
            r_stop    <= w_stop_n;
            r_fault   <= w_fault_n;
        end
    end

    assign imem_req_valid = (r_state == IFU_REQ);
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == IFU_HOLD) & ~redirect_valid;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign halted         = (r_state == IFU_HALT);
    assign fetch_fault    = r_fault;

endmodule

// File: tb/tb_ysyx_24110015_ifu.sv
// Bench for the fetch unit: word memory with programmable latency plus a
// program-order model (pc advances by 4, redirect target replaces it).
module tb_ysyx_24110015_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        halted;
    logic        fetch_fault;

    int          checks = 0;
    int          failures = 0;
    int          lat = 1;
    logic [31:0] err_addr = 32'h1;
    logic [31:0] salt;
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_addr;
    int          ovl_err = 0;

    ysyx_24110015_ifu dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .halted(halted), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Memory: answers each accepted request after lat cycles; flags overlapping or misaligned requests.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0; m_cnt <= 0; m_addr <= 32'h0;
            imem_rsp_valid <= 1'b0; imem_rsp_data <= 32'h0; imem_rsp_err <= 1'b0;
        end else begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_err   <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 0) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_word(m_addr);
                    imem_rsp_err   <= (m_addr == err_addr);
                    m_busy         <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                if (m_busy || imem_req_addr[1:0] != 2'b00) ovl_err <= ovl_err + 1;
                m_busy <= 1'b1;
                m_addr <= imem_req_addr;
                m_cnt  <= lat - 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
        imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1; err_addr = 32'h1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got req=%b inst=%b want 0/0", imem_req_valid, inst_valid);
        end
        checks++;
        if (inst !== 32'h0 || inst_pc !== RST_PC) begin
            failures++; $display("FAIL reset_inst got %h/%h want 0/%h", inst, inst_pc, RST_PC);
        end
        checks++;
        if (halted !== 1'b0 || fetch_fault !== 1'b0) begin
            failures++; $display("FAIL reset_status got halted=%b fault=%b want 0/0", halted, fetch_fault);
        end
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL idle_cycle got req=%b want 0", imem_req_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            failures++; $display("FAIL first_req got %b/%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC);
        end
    endtask

    task automatic test_seq();
        logic [31:0] ra[3]; logic [31:0] dpc[3]; int rcy[3]; int dcy[3];
        int rn = 0; int dn = 0;
        for (int k = 0; k < 3; k++) begin ra[k] = 0; dpc[k] = 0; rcy[k] = -1; dcy[k] = -1; end
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            if (imem_req_valid && imem_req_ready && rn < 3) begin ra[rn] = imem_req_addr; rcy[rn] = i; rn++; end
            if (inst_valid && inst_ready && dn < 3) begin
                checks++;
                if (inst !== mem_word(inst_pc)) begin
                    failures++; $display("FAIL seq_data pc=%h got %h want %h", inst_pc, inst, mem_word(inst_pc));
                end
                dpc[dn] = inst_pc; dcy[dn] = i; dn++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ra[k] !== RST_PC + 32'(4 * k) || rcy[k] != 4 * k) begin
                failures++; $display("FAIL seq_req[%0d] got %h@%0d want %h@%0d", k, ra[k], rcy[k], RST_PC + 32'(4 * k), 4 * k);
            end
            checks++;
            if (dpc[k] !== RST_PC + 32'(4 * k) || dcy[k] != 3 + 4 * k) begin
                failures++; $display("FAIL seq_inst[%0d] got %h@%0d want %h@%0d", k, dpc[k], dcy[k], RST_PC + 32'(4 * k), 3 + 4 * k);
            end
        end
    endtask

    task automatic test_stall();
        logic found = 1'b0; logic bad = 1'b0;
        do_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin @(negedge clk); #1; found = inst_valid; end
        checks++;
        if (!found) begin failures++; $display("FAIL stall_timeout got no inst_valid want 1"); end
        for (int s = 0; s < 5; s++) begin
            if (s > 0) begin @(negedge clk); #1; end
            if (inst_valid !== 1'b1 || inst_pc !== RST_PC || inst !== mem_word(RST_PC) || imem_req_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL stall_hold got pc=%h inst=%h req=%b want %h/%h/0", inst_pc, inst, imem_req_valid, RST_PC, mem_word(RST_PC)); end
        @(negedge clk); inst_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC + 32'd4) begin
            failures++; $display("FAIL stall_next got %b/%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        localparam logic [31:0] TGT = 32'h8000_0100;
        logic hs = 1'b0; logic saw_old = 1'b0; logic got_req = 1'b0; logic got_inst = 1'b0;
        logic [31:0] req_a = 0; logic [31:0] ipc = 0; logic [31:0] idat = 0; int ov0 = ovl_err;
        do_reset();
        lat = 3;
        for (int i = 0; i < 10 && !hs; i++) begin @(negedge clk); #1; hs = imem_req_valid && imem_req_ready; end
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = TGT;
        @(negedge clk); redirect_valid = 1'b0;
        for (int i = 0; i < 30 && !got_inst; i++) begin
            @(negedge clk); #1;
            if (imem_req_valid && imem_req_ready && !got_req) begin got_req = 1'b1; req_a = imem_req_addr; end
            if (inst_valid && inst_ready) begin
                if (inst_pc == RST_PC) saw_old = 1'b1;
                else begin got_inst = 1'b1; ipc = inst_pc; idat = inst; end
            end
        end
        checks++;
        if (!hs || req_a !== TGT) begin failures++; $display("FAIL rdw_req got %h want %h", req_a, TGT); end
        checks++;
        if (saw_old || ipc !== TGT || idat !== mem_word(TGT)) begin
            failures++; $display("FAIL rdw_inst got pc=%h inst=%h old=%b want %h/%h/0", ipc, idat, saw_old, TGT, mem_word(TGT));
        end
        checks++;
        if (ovl_err != ov0) begin failures++; $display("FAIL rdw_mem got %0d want %0d", ovl_err, ov0); end
    endtask

    task automatic test_redirect_hs();
        logic [31:0] tgt = 32'h8000_1000 | ($urandom & 32'h0000_0FFC);
        logic found = 1'b0; logic got = 1'b0; logic [31:0] ipc = 0;
        do_reset();
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk); #1;
            if (inst_valid) begin
                found = 1'b1;
                redirect_valid = 1'b1; redirect_pc = tgt; #1;
                checks++;
                if (inst_valid !== 1'b0) begin failures++; $display("FAIL rhs_squash got %b want 0", inst_valid); end
            end
        end
        @(negedge clk); redirect_valid = 1'b0; #1;
        checks++;
        if (!found || imem_req_valid !== 1'b1 || imem_req_addr !== tgt) begin
            failures++; $display("FAIL rhs_req got %b/%h want 1/%h", imem_req_valid, imem_req_addr, tgt);
        end
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk); #1;
            if (inst_valid && inst_ready) begin got = 1'b1; ipc = inst_pc; end
        end
        checks++;
        if (ipc !== tgt) begin failures++; $display("FAIL rhs_inst got %h want %h", ipc, tgt); end
    endtask

    task automatic test_fault();
        logic done = 1'b0; logic saw_bad = 1'b0; logic leak = 1'b0; logic found = 1'b0;
        do_reset();
        err_addr = RST_PC + 32'd4;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk); #1;
            if (inst_valid && inst_ready && inst_pc == err_addr) saw_bad = 1'b1;
            done = halted;
        end
        checks++;
        if (!done || fetch_fault !== 1'b1 || saw_bad) begin
            failures++; $display("FAIL err_halt got halted=%b fault=%b leaked=%b want 1/1/0", halted, fetch_fault, saw_bad);
        end
        for (int i = 0; i < 6; i++) begin @(negedge clk); #1; if (imem_req_valid || inst_valid || !halted) leak = 1'b1; end
        checks++;
        if (leak) begin failures++; $display("FAIL err_quiet got activity=1 want 0"); end
        do_reset(); #1;
        checks++;
        if (fetch_fault !== 1'b0) begin failures++; $display("FAIL fault_clear got %b want 0", fetch_fault); end
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk); #1;
            if (inst_valid) begin found = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0102; end
        end
        @(negedge clk); redirect_valid = 1'b0; #1;
        checks++;
        if (!found || halted !== 1'b1 || fetch_fault !== 1'b1) begin
            failures++; $display("FAIL misalign got halted=%b fault=%b want 1/1", halted, fetch_fault);
        end
        leak = 1'b0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); #1; if (imem_req_valid || inst_valid) leak = 1'b1; end
        checks++;
        if (leak) begin failures++; $display("FAIL misalign_quiet got activity=1 want 0"); end
    endtask

    task automatic test_halt_reset();
        logic hs = 1'b0; logic leak = 1'b0; logic got = 1'b0; int n = -1;
        logic [31:0] ra = 0; logic [31:0] ipc = 0; logic [31:0] idat = 0; int ov0;
        do_reset();
        lat = 3;
        for (int i = 0; i < 10 && !hs; i++) begin @(negedge clk); #1; hs = imem_req_valid && imem_req_ready; end
        @(negedge clk); halt = 1'b1;
        @(negedge clk); halt = 1'b0; #1;
        checks++;
        if (halted !== 1'b0) begin failures++; $display("FAIL halt_drain got halted=%b want 0", halted); end
        for (int i = 1; i < 10 && n < 0; i++) begin
            @(negedge clk); #1;
            if (inst_valid || imem_req_valid) leak = 1'b1;
            if (halted) n = i;
        end
        checks++;
        if (n != 3 || leak || fetch_fault !== 1'b0) begin
            failures++; $display("FAIL halt_wait got cycles=%0d leak=%b fault=%b want 3/0/0", n, leak, fetch_fault);
        end
        do_reset();
        lat = 2; hs = 1'b0; got = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk); #1;
            if (inst_valid && inst_ready) got = 1'b1;
            hs = got && imem_req_valid && imem_req_ready;
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== RST_PC ||
            halted !== 1'b0 || fetch_fault !== 1'b0) begin
            failures++; $display("FAIL midreset got req=%b iv=%b inst=%h pc=%h h=%b f=%b want 0/0/0/%h/0/0",
                imem_req_valid, inst_valid, inst, inst_pc, halted, fetch_fault, RST_PC);
        end
        ov0 = ovl_err;
        @(negedge clk); @(negedge clk); rst = 1'b1; lat = 1; hs = 1'b0; got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk); #1;
            if (imem_req_valid && imem_req_ready && !hs) begin hs = 1'b1; ra = imem_req_addr; end
            if (inst_valid && inst_ready) begin got = 1'b1; ipc = inst_pc; idat = inst; end
        end
        checks++;
        if (ra !== RST_PC || ipc !== RST_PC || idat !== mem_word(RST_PC) || ovl_err != ov0) begin
            failures++; $display("FAIL restart got req=%h pc=%h inst=%h want %h/%h/%h", ra, ipc, idat, RST_PC, RST_PC, mem_word(RST_PC));
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc = RST_PC; logic started = 1'b0; int n = 0; int bad = 0; int ov0 = ovl_err;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            imem_req_ready = ($urandom % 4) != 0;
            inst_ready     = ($urandom % 3) != 0;
            lat            = int'($urandom_range(1, 3));
            redirect_valid = started && (($urandom % 20) == 0);
            redirect_pc    = 32'h8000_0000 | ($urandom & 32'h0000_3FFC);
            #1;
            if (redirect_valid) begin
                checks++;
                if (inst_valid !== 1'b0) begin failures++; bad++; $display("FAIL rnd_squash got %b want 0", inst_valid); end
                exp_pc = redirect_pc;
            end else if (inst_valid && inst_ready) begin
                checks++;
                if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    failures++; bad++;
                    if (bad < 5) $display("FAIL rnd_inst got %h/%h want %h/%h", inst_pc, inst, exp_pc, mem_word(exp_pc));
                    exp_pc = inst_pc;
                end
                exp_pc  = exp_pc + 32'd4;
                started = 1'b1;
                n++;
            end
        end
        redirect_valid = 1'b0;
        checks++;
        if (n < 40 || ovl_err != ov0) begin
            failures++; $display("FAIL rnd_progress got insts=%0d memerr=%0d want >=40/0", n, ovl_err - ov0);
        end
    endtask

    initial begin
        salt = $urandom;
        test_reset();
        test_seq();
        test_stall();
        test_redirect_wait();
        test_redirect_hs();
        test_fault();
        test_halt_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
